sprite_compositor: RTL and testbench

Pixel back-end stage directly downstream of the per-sprite renderers. Takes the colour-index and drawing flag from NUM_SPR sprite instances plus a background index, resolves layer priority and transparency, maps the winning index through a writable palette to 24-bit RGB, and delays the VGA sync/blanking signals to stay aligned with the pixel. Palette writes from the CPU side are buffered and committed only during blanking so no visible tearing occurs mid-pixel.

---
 rtl/sprite_compositor_pkg.sv | 24 ++
 rtl/sprite_compositor_palette_ram.sv | 50 +++++
 rtl/sprite_compositor.sv | 176 +++++++++++++++++
 tb/tb_sprite_compositor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_compositor_pkg.sv
// Shared definitions for the sprite compositor and its palette store.
// Contents: palette width/depth constants, packed RGB type, write-buffer
// state encoding, and the default transparent colour index.
package sprite_compositor_pkg;

    // Palette entries are {R,G,B}, 8 bits per channel.
    localparam int unsigned PalDataW         = 24;
    localparam int unsigned DefaultIdxW      = 4;
    localparam int unsigned DefaultPalDepth  = 2 ** DefaultIdxW;
    localparam int unsigned DefaultTranspIdx = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // CPU palette write buffer.
    typedef enum logic {
        StEmpty   = 1'b0,
        StPending = 1'b1
    } wbuf_state_e;

endpackage

// File: rtl/sprite_compositor_palette_ram.sv
// Palette register file: 2**AddrW entries of DataW bits, all reset to zero.
// One synchronous write port and one registered read port. When rd_en_i is
// low the read register loads zero, which lets the caller blank the output
// without an extra pipeline register.
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   we_i/waddr_i/wdata_i  write port
//   rd_en_i/raddr_i   read request
//   rd_data_o         registered read data (entry or zero)
module sprite_compositor_palette_ram #(
    parameter int unsigned AddrW = 4,
    parameter int unsigned DataW = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic             rd_en_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [DataW-1:0] rd_data_o
);

    localparam int unsigned Depth = 2 ** AddrW;

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] mem_d [Depth];
    logic [DataW-1:0] rd_data_q, rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
        // Reads the pre-write contents: a write lands for the next cycle's read.
        rd_data_d = rd_en_i ? mem_q[raddr_i] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q     <= '{default: '0};
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: picks the highest-priority opaque sprite layer (lowest
// layer number) or the background, maps the index through a CPU-writable
// palette to 24-bit RGB, and delays the syncs to stay aligned (2 cycles).
// CPU palette writes are held in a one-entry buffer and committed only while
// h_bright is low.
// Optional feature: define COMPOSITOR_COLLISION_EN for sticky per-layer
// collision flags; otherwise collision is tied to 0 and coll_clr is ignored.
// Ports:
//   clk, reset (async, active-low)
//   h_bright, hsync_i, vsync_i       timing generator inputs
//   spr_pix, spr_drawing, bg_pix     layer indices and drawing flags
//   pal_we, pal_addr, pal_data       palette write request; pal_busy out
//   coll_clr                         collision flag clear
//   vga_r/g/b, hsync_o, vsync_o, bright_o, collision   outputs
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int unsigned NUM_SPR    = 4,
    parameter int unsigned SPR_DATAW  = 4,
    parameter int unsigned TRANSP_IDX = DefaultTranspIdx
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         h_bright,
    input  logic                         hsync_i,
    input  logic                         vsync_i,
    input  logic [NUM_SPR*SPR_DATAW-1:0] spr_pix,
    input  logic [NUM_SPR-1:0]           spr_drawing,
    input  logic [SPR_DATAW-1:0]         bg_pix,
    input  logic                         pal_we,
    input  logic [SPR_DATAW-1:0]         pal_addr,
    input  logic [PalDataW-1:0]          pal_data,
    output logic                         pal_busy,
    input  logic                         coll_clr,
    output logic [7:0]                   vga_r,
    output logic [7:0]                   vga_g,
    output logic [7:0]                   vga_b,
    output logic                         hsync_o,
    output logic                         vsync_o,
    output logic                         bright_o,
    output logic [NUM_SPR-1:0]           collision
);

    localparam logic [SPR_DATAW-1:0] TranspIdx = SPR_DATAW'(TRANSP_IDX);

    // Stage 1: layer select.
    logic [NUM_SPR-1:0]   opaque;
    logic [SPR_DATAW-1:0] win_idx;
    logic [SPR_DATAW-1:0] sel_idx_q, sel_idx_d;
    // Sync bundles {hsync, vsync, bright}; sync1_q[0] is the stage-1 bright.
    logic [2:0]           sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        opaque  = '0;
        win_idx = bg_pix;
        // Walk from the top layer down so the lowest-numbered opaque layer wins.
        for (int k = NUM_SPR - 1; k >= 0; k--) begin
            opaque[k] = spr_drawing[k] && (spr_pix[k*SPR_DATAW +: SPR_DATAW] != TranspIdx);
            if (opaque[k]) begin
                win_idx = spr_pix[k*SPR_DATAW +: SPR_DATAW];
            end
        end
        sel_idx_d = win_idx;
        sync1_d   = {hsync_i, vsync_i, h_bright};
        sync2_d   = sync1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_idx_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            sel_idx_q <= sel_idx_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    assign {hsync_o, vsync_o, bright_o} = sync2_q;

    // Palette write buffer.
    wbuf_state_e          wb_state_q, wb_state_d;
    logic [SPR_DATAW-1:0] wb_addr_q, wb_addr_d;
    logic [PalDataW-1:0]  wb_data_q, wb_data_d;
    logic                 pal_commit;

    always_comb begin
        wb_state_d = wb_state_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        pal_commit = 1'b0;
        unique case (wb_state_q)
            StEmpty: begin
                if (pal_we) begin
                    wb_addr_d  = pal_addr;
                    wb_data_d  = pal_data;
                    wb_state_d = StPending;
                end
            end
            StPending: begin
                // Requests arriving here are dropped; caller polls pal_busy.
                if (!h_bright) begin
                    pal_commit = 1'b1;
                    wb_state_d = StEmpty;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_state_q <= StEmpty;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_state_q <= wb_state_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign pal_busy = (wb_state_q == StPending);

    // Stage 2: palette lookup, blanked to black outside active video.
    logic [PalDataW-1:0] rd_data;
    rgb_t                px;

    sprite_compositor_palette_ram #(
        .AddrW (SPR_DATAW),
        .DataW (PalDataW)
    ) u_palette_ram (
        .clk_i     (clk),
        .rst_ni    (reset),
        .we_i      (pal_commit),
        .waddr_i   (wb_addr_q),
        .wdata_i   (wb_data_q),
        .rd_en_i   (sync1_q[0]),
        .raddr_i   (sel_idx_q),
        .rd_data_o (rd_data)
    );

    assign px    = rd_data;
    assign vga_r = px.r;
    assign vga_g = px.g;
    assign vga_b = px.b;

`ifdef COMPOSITOR_COLLISION_EN
    logic [NUM_SPR-1:0] coll_q, coll_d, coll_set;

    always_comb begin
        coll_set = '0;
        // More than one opaque layer: clearing the lowest set bit leaves something.
        if (h_bright && ((opaque & (opaque - NUM_SPR'(1))) != '0)) begin
            coll_set = opaque;
        end
        // A new collision outranks a simultaneous clear.
        coll_d = (coll_clr ? '0 : coll_q) | coll_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coll_q <= '0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign collision = coll_q;
`else
    logic unused_coll_clr;
    assign unused_coll_clr = coll_clr;
    assign collision       = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios then random traffic, all
// checked every cycle against a cycle-level behavioural model.
module tb_sprite_compositor;

    localparam int NS = 4;
    localparam int DW = 4;
    localparam int TI = 0;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           h_bright = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0;
    logic [NS*DW-1:0] spr_pix = '0;
    logic [NS-1:0]  spr_drawing = '0;
    logic [DW-1:0]  bg_pix = '0;
    logic           pal_we = 1'b0;
    logic [DW-1:0]  pal_addr = '0;
    logic [23:0]    pal_data = '0;
    logic           pal_busy;
    logic           coll_clr = 1'b0;
    logic [7:0]     vga_r, vga_g, vga_b;
    logic           hsync_o, vsync_o, bright_o;
    logic [NS-1:0]  collision;

    always #5 clk = ~clk;

    sprite_compositor #(
        .NUM_SPR    (NS),
        .SPR_DATAW  (DW),
        .TRANSP_IDX (TI)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .h_bright    (h_bright),
        .hsync_i     (hsync_i),
        .vsync_i     (vsync_i),
        .spr_pix     (spr_pix),
        .spr_drawing (spr_drawing),
        .bg_pix      (bg_pix),
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_data    (pal_data),
        .pal_busy    (pal_busy),
        .coll_clr    (coll_clr),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hsync_o     (hsync_o),
        .vsync_o     (vsync_o),
        .bright_o    (bright_o),
        .collision   (collision)
    );

    // Reference model state.
    logic [23:0]   m_pal [2**DW];
    logic          m_pend;
    logic [DW-1:0] m_paddr;
    logic [23:0]   m_pdata;
    logic [DW-1:0] m_idx;
    logic          m_bright1;
    logic [23:0]   m_rgb;
    logic [1:0]    m_hs, m_vs, m_br;
    logic [NS-1:0] m_coll;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2**DW; i++) m_pal[i] = '0;
        m_pend = 0; m_paddr = '0; m_pdata = '0;
        m_idx = '0; m_bright1 = 0; m_rgb = '0;
        m_hs = '0; m_vs = '0; m_br = '0; m_coll = '0;
    endtask

    // What the pipeline does at one rising edge, from the pre-edge inputs.
    task automatic model_edge();
        int n_opaque;
        logic found;
        logic [DW-1:0] w;
        logic [NS-1:0] op;
        m_rgb = m_bright1 ? m_pal[m_idx] : 24'h0;
        n_opaque = 0; found = 0; w = bg_pix; op = '0;
        for (int k = 0; k < NS; k++) begin
            logic [DW-1:0] v;
            v = spr_pix[k*DW +: DW];
            if (spr_drawing[k] && v != DW'(TI)) begin
                op[k] = 1'b1;
                n_opaque++;
                if (!found) begin w = v; found = 1; end
            end
        end
`ifdef COMPOSITOR_COLLISION_EN
        m_coll = (coll_clr ? '0 : m_coll) | ((h_bright && n_opaque > 1) ? op : '0);
`endif
        m_idx = w;
        m_bright1 = h_bright;
        m_hs = {m_hs[0], hsync_i};
        m_vs = {m_vs[0], vsync_i};
        m_br = {m_br[0], h_bright};
        if (m_pend) begin
            if (!h_bright) begin
                m_pal[m_paddr] = m_pdata;
                m_pend = 0;
            end
        end else if (pal_we) begin
            m_paddr = pal_addr; m_pdata = pal_data; m_pend = 1;
        end
    endtask

    task automatic check_all();
        chk("rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, m_rgb});
        chk("hsync_o", 32'(hsync_o), 32'(m_hs[1]));
        chk("vsync_o", 32'(vsync_o), 32'(m_vs[1]));
        chk("bright_o", 32'(bright_o), 32'(m_br[1]));
        chk("pal_busy", 32'(pal_busy), 32'(m_pend));
        chk("collision", 32'(collision), 32'(m_coll));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) model_edge();
        #1;
        check_all();
    endtask

    task automatic rand_inputs();
        h_bright    = ($urandom_range(0, 3) != 0);
        hsync_i     = 1'($urandom);
        vsync_i     = 1'($urandom);
        spr_pix     = 16'($urandom);
        spr_drawing = 4'($urandom);
        bg_pix      = 4'($urandom);
        pal_we      = ($urandom_range(0, 7) == 0);
        pal_addr    = 4'($urandom);
        pal_data    = 24'($urandom);
        coll_clr    = ($urandom_range(0, 15) == 0);
    endtask

    task automatic pal_write(input logic [DW-1:0] a, input logic [23:0] d);
        h_bright = 0; pal_we = 1; pal_addr = a; pal_data = d;
        cyc();
        pal_we = 0;
        cyc();
        cyc();
    endtask

    logic [NS-1:0] exp_coll;

    initial begin
        model_reset();
        // Reset held with random inputs: everything stays at zero.
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            cyc();
        end
        chk("reset_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("reset_busy", 32'(pal_busy), 32'h0);

        // Release: background index with a zeroed palette gives black.
        reset = 1; pal_we = 0; coll_clr = 0; spr_drawing = '0; bg_pix = 4'h7; h_bright = 1;
        cyc(); cyc();
        chk("post_reset_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);

        pal_write(4'h5, 24'hFF0000);
        pal_write(4'h9, 24'h123456);

        // Priority: layers 1 and 2 drawing, layer 1 wins.
        h_bright = 1; spr_drawing = 4'b0110; spr_pix = 16'hA953;
        cyc(); cyc();
        chk("prio_l1", {8'h0, vga_r, vga_g, vga_b}, 32'hFF0000);
        spr_pix = 16'hA903;
        cyc(); cyc();
        chk("prio_transp", {8'h0, vga_r, vga_g, vga_b}, 32'h123456);

        // Blanking: opaque sprite but h_bright low.
        h_bright = 0; hsync_i = 1; vsync_i = 0; spr_drawing = 4'b0001; spr_pix = 16'h0005;
        cyc();
        hsync_i = 0; vsync_i = 1;
        cyc();
        chk("blank_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("blank_bright", 32'(bright_o), 32'h0);
        chk("blank_hsync", 32'(hsync_o), 32'h1);
        cyc();
        chk("blank_vsync", 32'(vsync_o), 32'h1);

        // Deferred write mid-line; a second request while busy is dropped.
        h_bright = 1; spr_drawing = 4'b0001; spr_pix = 16'h0003;
        pal_we = 1; pal_addr = 4'h3; pal_data = 24'h00FF00;
        cyc();
        chk("defer_busy", 32'(pal_busy), 32'h1);
        pal_data = 24'hABCDEF;
        cyc();
        pal_we = 0;
        chk("defer_busy2", 32'(pal_busy), 32'h1);
        cyc(); cyc(); cyc();
        chk("defer_hold", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        h_bright = 0;
        cyc();
        h_bright = 1;
        cyc(); cyc();
        chk("defer_new", {8'h0, vga_r, vga_g, vga_b}, 32'h00FF00);
        chk("defer_idle", 32'(pal_busy), 32'h0);
        cyc(); cyc();
        chk("defer_drop", {8'h0, vga_r, vga_g, vga_b}, 32'h00FF00);

        // Collision: layers 0 and 3 opaque together; clear with a new overlap.
`ifdef COMPOSITOR_COLLISION_EN
        exp_coll = 4'b1001;
`else
        exp_coll = 4'b0000;
`endif
        coll_clr = 1; spr_drawing = '0;
        cyc();
        coll_clr = 0; spr_drawing = 4'b1001; spr_pix = 16'h6002;
        cyc();
        chk("coll_set", 32'(collision), 32'(exp_coll));
        coll_clr = 1;
        cyc();
        chk("coll_clr_vs_set", 32'(collision), 32'(exp_coll));
        spr_drawing = 4'b1000;
        cyc();
        chk("coll_cleared", 32'(collision), 32'h0);
        coll_clr = 0;

        // Reset while a write is pending discards it.
        h_bright = 1; pal_we = 1; pal_addr = 4'hE; pal_data = 24'h777777;
        cyc();
        pal_we = 0;
        cyc();
        chk("rst_pend_busy", 32'(pal_busy), 32'h1);
        reset = 0;
        #1;
        model_reset();
        chk("rst_async_busy", 32'(pal_busy), 32'h0);
        check_all();
        cyc();
        reset = 1; spr_drawing = '0; bg_pix = 4'hE; h_bright = 0;
        cyc(); cyc();
        h_bright = 1;
        cyc(); cyc(); cyc();
        chk("rst_discard", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("rst_discard_busy", 32'(pal_busy), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
